serial_pattern_timer: RTL
=========================

Name: serial_pattern_timer

Overview:
- Parametrised controller and datapath for the detect → capture → load → count-down flow.
- After a start handshake it watches a serial input for a configurable PATTERN, then shifts in a LEN-bit payload.
- It then loads a down counter with that payload and holds busy high for exactly that many cycles before pulsing done.
- Adds an abort input, a zero-payload bypass and optional auto re-arm; sits between a serial source and the unit it times.

Parameters:
- PAT_W, 4, pattern width in bits (≥2).
- PATTERN, 4'b1101, pattern to detect, MSB received first.
- LEN, 8, payload width in bits; also down-counter width.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin request; level, sampled in IDLE/INIT only.
- sin  input  1  serial data, one bit per cycle.
- abort  input  1  cancel current operation.
- ready  output  1  high in IDLE.
- busy  output  1  high in DOWNCOUNT.
- done  output  1  one-cycle completion pulse.
- count_val  output  LEN  current down-counter value.

Behaviour:
- Reset: synchronous; rst=1 at a rising edge forces state IDLE, window=0, payload=0, bit counter=0, down counter=0.
  - Outputs after reset: ready=1, busy=0, done=0, count_val=0. rst has priority over everything.
- Outputs are Moore-decoded from the state register; count_val is the down-counter register.
- States:
  - IDLE: ready=1. start=1 → INIT, else stay.
  - INIT: window and bit counter cleared every cycle. start=1 → stay; start=0 → DETECT.
  - DETECT: window <= {window[PAT_W-2:0], sin}.
    - Match is checked on that next value; match → SHIFT next cycle.
    - Overlapping patterns are detected; at least PAT_W bits must arrive after INIT.
  - SHIFT: payload <= {payload[LEN-2:0], sin} (MSB first); bit counter increments.
    - After the LEN-th bit → LOAD. SHIFT lasts exactly LEN cycles.
  - LOAD: one cycle; down counter <= payload. payload==0 → DONE, else → DOWNCOUNT.
  - DOWNCOUNT: busy=1; counter decrements each cycle. Leave for DONE when counter==1, i.e. it reaches 0 on the exit edge.
    - busy stays high exactly payload cycles; count_val reads P, P-1, …, 1 during busy and 0 in DONE.
  - DONE: done=1 for one cycle → IDLE.
- abort=1 in any state other than IDLE → IDLE on the next edge.
  - Overrides the normal transition; no done pulse.
  - Down counter is cleared so count_val=0 in IDLE.
- start is ignored in DETECT, SHIFT, LOAD, DOWNCOUNT and DONE.
- Unused state encodings → IDLE.
- Latency from the last pattern bit to busy rising: LEN+2 cycles.

Optional Feature:
- Macro: SERIAL_PATTERN_TIMER_AUTO_REARM_EN.
- Defined: DONE → DETECT (window cleared in DONE), so the block re-arms without a new start. ready stays 0 until abort returns it to IDLE.
- Undefined: DONE → IDLE as above.

Test Plan:
- Reset: drive rst=1 for 2 cycles mid-DOWNCOUNT → ready=1, busy=0, done=0, count_val=0 on the cycle after reset release.
- Normal flow: start=1 for 1 cycle, then sin=0,1,1,0,1, then payload 00000011.
  - Expect busy=1 for exactly 3 cycles with count_val=3,2,1.
  - Then done=1 for 1 cycle with count_val=0, then ready=1.
- Zero payload: pattern followed by 00000000 → busy never asserts; done pulses on the cycle after LOAD.
- Overlap: after INIT, sin=1,1,0,1,1,0,1 → match on the 4th bit; SHIFT begins on the 5th, so payload MSB = 1.
- Abort: payload 11001000 (200); assert abort after 10 busy cycles → next cycle ready=1, busy=0, count_val=0, done never pulses.
- Start held / full range: start held 5 cycles → state stays INIT throughout. Payload 11111111 → busy exactly 255 cycles, single done pulse.
  - With SERIAL_PATTERN_TIMER_AUTO_REARM_EN defined, a second pattern after done restarts without start and ready stays 0.

Source files
------------

// File: rtl/serial_pattern_timer.sv
// Start handshake, serial pattern detect, LEN-bit payload capture, then a down-count with a busy window and done pulse.
// Optional build macro SERIAL_PATTERN_TIMER_AUTO_REARM_EN: DONE returns to DETECT instead of IDLE.
module serial_pattern_timer #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
  parameter int                 LEN     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sin,
  input  logic           abort,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] count_val
);

  localparam int CNT_MAX = (LEN > PAT_W) ? LEN : PAT_W;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_DETECT = 3'd2,
    S_SHIFT  = 3'd3,
    S_LOAD   = 3'd4,
    S_DOWN   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PAT_W-1:0] r_window;
  logic [LEN-1:0]   r_payload;
  logic [CW-1:0]    r_bitcnt;
  logic [LEN-1:0]   r_count;

  logic [PAT_W-1:0] w_window_next;
  logic             w_match;
  logic             w_shift_last;
  logic             w_abort;

  // In DETECT the bit counter tracks bits seen since INIT, so a match needs a full window of fresh bits.
  assign w_window_next = {r_window[PAT_W-2:0], sin};
  assign w_match       = (w_window_next == PATTERN) && (r_bitcnt >= CW'(PAT_W - 1));
  assign w_shift_last  = (r_bitcnt == CW'(LEN - 1));
  assign w_abort       = abort && (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_INIT;
      S_INIT:   if (!start) w_state_next = S_DETECT;
      S_DETECT: if (w_match) w_state_next = S_SHIFT;
      S_SHIFT:  if (w_shift_last) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = (r_payload == '0) ? S_DONE : S_DOWN;
      S_DOWN:   if (r_count == LEN'(1)) w_state_next = S_DONE;
`ifdef SERIAL_PATTERN_TIMER_AUTO_REARM_EN
      S_DONE:   w_state_next = S_DETECT;
`else
      S_DONE:   w_state_next = S_IDLE;
`endif
      default:  w_state_next = S_IDLE;
    endcase
    if (w_abort) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_window  <= '0;
      r_payload <= '0;
      r_bitcnt  <= '0;
      r_count   <= '0;
    end else if (w_abort) begin
      r_count <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_window <= '0;
          r_bitcnt <= '0;
        end
        S_DETECT: begin
          r_window <= w_window_next;
          if (w_match)                      r_bitcnt <= '0;
          else if (r_bitcnt < CW'(PAT_W))   r_bitcnt <= r_bitcnt + CW'(1);
        end
        S_SHIFT: begin
          r_payload <= {r_payload[LEN-2:0], sin};
          r_bitcnt  <= r_bitcnt + CW'(1);
        end
        S_LOAD: r_count <= r_payload;
        S_DOWN: r_count <= r_count - LEN'(1);
`ifdef SERIAL_PATTERN_TIMER_AUTO_REARM_EN
        S_DONE: begin
          r_window <= '0;
          r_bitcnt <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_DOWN);
  assign done      = (r_state == S_DONE);
  assign count_val = r_count;

endmodule
